// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port.
// Optional build macro WBQ_COALESCE_EN merges pushes to pending addresses.
module regfile_wb_queue #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(N),
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_addr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             drain_stall,
  output logic             W_en,
  output logic [AW-1:0]    W_addr,
  output logic [WIDTH-1:0] W_data,
  input  logic [AW-1:0]    lookup_addr,
  output logic             lookup_hit,
  output logic [WIDTH-1:0] lookup_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [AW-1:0]    q_addr [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;

  logic push;
  logic alloc;
  logic pop;

  assign count  = cnt;
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign W_en   = !empty && !drain_stall;
  assign W_addr = q_addr[head];
  assign W_data = q_data[head];
  assign pop    = W_en;
  assign push   = in_valid && in_ready;

`ifdef WBQ_COALESCE_EN
  logic          coal_hit;
  logic [PW-1:0] coal_idx;

  // find a pending entry with the pushed address, skipping a draining head
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && (q_addr[i] == in_addr) &&
          !((PW'(i) == head) && W_en)) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  assign in_ready = !full || coal_hit;
  assign alloc    = push && !coal_hit;
`else
  assign in_ready = !full;
  assign alloc    = push;
`endif

  // lookup walks oldest to youngest so the youngest match wins
  always_comb begin
    logic [PW-1:0] idx;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (q_valid[idx] && (q_addr[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = q_data[idx];
      end
    end
  end

  // entry storage, pointers and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      q_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (alloc) begin
        q_addr[tail]  <= in_addr;
        q_data[tail]  <= in_data;
        q_valid[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
`ifdef WBQ_COALESCE_EN
      if (push && coal_hit) begin
        q_data[coal_idx] <= in_data;
      end
`endif
    end
  end

  // occupancy counter: allocation adds, drain removes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({alloc, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomised bench for regfile_wb_queue against a queue-based model.
// Honours WBQ_COALESCE_EN when the design is built with it.
module tb_regfile_wb_queue;

  localparam int WIDTH = 32;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(N);
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_addr;
  logic [WIDTH-1:0] in_data;
  logic             drain_stall;
  logic             W_en;
  logic [AW-1:0]    W_addr;
  logic [WIDTH-1:0] W_data;
  logic [AW-1:0]    lookup_addr;
  logic             lookup_hit;
  logic [WIDTH-1:0] lookup_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;

  typedef struct {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   checks;
  int   errors;

  regfile_wb_queue #(
    .WIDTH(WIDTH),
    .N(N),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_data(in_data),
    .drain_stall(drain_stall),
    .W_en(W_en),
    .W_addr(W_addr),
    .W_data(W_data),
    .lookup_addr(lookup_addr),
    .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .count(count),
    .empty(empty),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock cycle: check outputs mid-cycle, then advance the model
  task automatic step();
    bit               e_wen;
    bit               e_rdy;
    bit               e_hit;
    logic [WIDTH-1:0] e_ld;
    int               m;
    @(negedge clk);
    e_wen = (mq.size() > 0) && !drain_stall;
    m = -1;
`ifdef WBQ_COALESCE_EN
    foreach (mq[i])
      if (mq[i].a == in_addr && !(i == 0 && e_wen)) m = i;
`endif
    e_rdy = (mq.size() < DEPTH) || (m >= 0);
    e_hit = 0;
    e_ld  = '0;
    foreach (mq[i])
      if (mq[i].a == lookup_addr) begin
        e_hit = 1;
        e_ld  = mq[i].d;
      end
    check("in_ready", in_ready, e_rdy);
    check("w_en", W_en, e_wen);
    if (e_wen) begin
      check("w_addr", W_addr, mq[0].a);
      check("w_data", W_data, mq[0].d);
    end
    check("lookup_hit", lookup_hit, e_hit);
    check("lookup_data", lookup_data, e_ld);
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    @(posedge clk);
    if (in_valid && e_rdy && m >= 0) mq[m].d = in_data;
    if (e_wen) void'(mq.pop_front());
    if (in_valid && e_rdy && m < 0) mq.push_back('{in_addr, in_data});
    #1;
  endtask

  task automatic drive(input bit v, input int a,
                       input logic [WIDTH-1:0] d, input bit st);
    in_valid    = v;
    in_addr     = AW'(a);
    in_data     = d;
    drain_stall = st;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_addr     = '0;
    in_data     = '0;
    drain_stall = 1'b0;
    lookup_addr = '0;
    #12;
    check("rst_wen", W_en, 0);
    check("rst_ready", in_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_hit", lookup_hit, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single push then commit
    drive(1, 3, 32'hA5A5_0001, 0);
    lookup_addr = 5'd3;
    step();
    drive(0, 0, 0, 0);
    step();
    step();
    check("tp1_empty", empty, 1);

    // stalled fill, then in-order drain
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 32'h100 + i, 1);
      step();
    end
    check("tp2_full", full, 1);
    check("tp2_count", count, 4);
    drive(1, 9, 32'h99, 1);
    step();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    check("tp2_empty", empty, 1);

    // duplicate address lookup
    lookup_addr = 5'd5;
    drive(1, 5, 32'h11, 1);
    step();
    drive(1, 5, 32'h22, 1);
    step();
    drive(0, 0, 0, 1);
    step();
    check("tp3_data", lookup_data, 32'h22);
`ifdef WBQ_COALESCE_EN
    check("tp3_count", count, 1);
`else
    check("tp3_count", count, 2);
`endif
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();

    // full queue with drain and request in the same cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 10 + i, 32'h200 + i, 1);
      step();
    end
    drive(1, 20, 32'h300, 0);
    check("tp4_ready_full", in_ready, 0);
    step();
    check("tp4_count3", count, 3);
    drive(1, 20, 32'h300, 1);
    step();
    check("tp4_count4", count, 4);

    // head lookup while draining
    lookup_addr = 5'd10;
    drive(0, 0, 0, 0);
    step();
    check("tp5_hit_after", lookup_hit, 0);
    for (int i = 0; i < 4; i++) step();

    // asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) begin
      drive(1, 1 + i, 32'h400 + i, 1);
      step();
    end
    drive(0, 0, 0, 0);
    lookup_addr = 5'd2;
    @(negedge clk);
    check("tp6_pre_wen", W_en, 1);
    rst = 1'b1;
    #1;
    check("tp6_wen", W_en, 0);
    check("tp6_count", count, 0);
    check("tp6_empty", empty, 1);
    check("tp6_hit", lookup_hit, 0);
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // randomised traffic with a small address range to force duplicates
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7),
            $urandom, $urandom_range(0, 9) < 3);
      lookup_addr = AW'($urandom_range(0, 7));
      step();
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step();
    check("final_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
